// File: rtl/pc_ir_status_unit.sv
// PC, instruction register and status register stage for the LEGv8 control unit.
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   PS, PCsel        : PC select (hold/inc/abs/rel) and branch operand select
//   IL, SL           : instruction load and status load strobes
//   constant, reg_a  : branch operand sources (constant in word units)
//   imem_data        : instruction memory read data at address pc
//   alu_flags        : ALU flags {V,C,N,Z}, current cycle
//   pc, I, instr_pc  : fetch address, instruction register, its address
//   pc4              : instr_pc + 4 link value
//   status           : {registered V,C,N,Z, live Z}
//   pc_fault         : sticky misaligned absolute-target flag
module pc_ir_status_unit #(
    parameter int            N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   PS,
    input  logic         PCsel,
    input  logic         IL,
    input  logic         SL,
    input  logic [N-1:0] constant,
    input  logic [N-1:0] reg_a,
    input  logic [31:0]  imem_data,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] pc,
    output logic [31:0]  I,
    output logic [N-1:0] instr_pc,
    output logic [N-1:0] pc4,
    output logic [4:0]   status,
    output logic         pc_fault
);

    localparam logic [N-1:0] FOUR = {{(N-3){1'b0}}, 3'd4};

    logic [N-1:0] opnd;
    logic [N-1:0] pc_inc;
    logic [N-1:0] abs_tgt;
    logic [N-1:0] rel_tgt;
    logic [N-1:0] pc_next;
    logic         misalign;
    logic         fault_set;
    logic [3:0]   flags_q;

    assign opnd     = PCsel ? constant : reg_a;
    assign pc_inc   = pc + FOUR;
    // Absolute targets are forced to a word boundary; the low bits only
    // serve to detect a misaligned request.
    assign abs_tgt  = {opnd[N-1:2], 2'b00};
    assign misalign = |opnd[1:0];
    // Relative branches are based on the address of the branch itself,
    // not on the already-incremented fetch PC.
    assign rel_tgt  = instr_pc + (opnd << 2);

    always_comb begin
        pc_next   = pc;
        fault_set = 1'b0;
        unique case (PS)
            2'b00: pc_next = pc;
            2'b01: pc_next = pc_inc;
            2'b10: begin
                pc_next   = abs_tgt;
                fault_set = misalign;
            end
            2'b11: pc_next = rel_tgt;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr_pc <= RESET_PC;
            I        <= 32'h0;
            flags_q  <= 4'h0;
            pc_fault <= 1'b0;
        end else begin
            pc <= pc_next;
            if (fault_set)
                pc_fault <= 1'b1;
            // The captured address is the pre-update pc, even when a
            // branch moves pc in the same cycle.
            if (IL) begin
                I        <= imem_data;
                instr_pc <= pc;
            end
            if (SL)
                flags_q <= alu_flags;
        end
    end

    assign pc4    = instr_pc + FOUR;
    // Bit 0 bypasses the register so CBZ/CBNZ see this cycle's zero flag.
    assign status = {flags_q, alu_flags[0]};

endmodule

// File: tb/tb_pc_ir_status_unit.sv
// Directed bench for pc_ir_status_unit with a per-cycle reference model.
// Literal checks pin the model against hand-computed values.
module tb_pc_ir_status_unit;

    localparam logic [63:0] RPC = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  PS;
    logic        PCsel, IL, SL;
    logic [63:0] constant, reg_a;
    logic [31:0] imem_data;
    logic [3:0]  alu_flags;
    logic [63:0] pc, instr_pc, pc4;
    logic [31:0] I;
    logic [4:0]  status;
    logic        pc_fault;

    int total = 0;
    int bad   = 0;

    pc_ir_status_unit #(.N(64), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .PS(PS), .PCsel(PCsel),
        .IL(IL), .SL(SL), .constant(constant), .reg_a(reg_a),
        .imem_data(imem_data), .alu_flags(alu_flags),
        .pc(pc), .I(I), .instr_pc(instr_pc), .pc4(pc4),
        .status(status), .pc_fault(pc_fault)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_ir;
    logic [3:0]  m_flags;
    logic        m_fault;
    bit          m_valid = 0;

    always @(posedge clock) begin
        logic [63:0] o, npc;
        if (reset) begin
            m_pc = RPC; m_ipc = RPC; m_ir = 0;
            m_flags = 0; m_fault = 0; m_valid = 1;
        end else if (m_valid) begin
            o = PCsel ? constant : reg_a;
            npc = m_pc;
            if (PS == 2'd1) npc = m_pc + 64'd4;
            else if (PS == 2'd2) begin
                npc = o - (o % 64'd4);
                if (o % 64'd4 != 0) m_fault = 1;
            end else if (PS == 2'd3) npc = m_ipc + o * 64'd4;
            if (IL) begin
                m_ir  = imem_data;
                m_ipc = m_pc;
            end
            if (SL) m_flags = alu_flags;
            m_pc = npc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            chk("m_pc", pc, m_pc);
            chk("m_instr_pc", instr_pc, m_ipc);
            chk("m_I", {32'h0, I}, {32'h0, m_ir});
            chk("m_pc4", pc4, m_ipc + 64'd4);
            chk("m_status", {59'h0, status},
                {59'h0, m_flags, alu_flags[0]});
            chk("m_fault", {63'h0, pc_fault}, {63'h0, m_fault});
        end
    end

    task automatic step(input logic [1:0] ps, input logic sel,
                        input logic il, input logic sl,
                        input logic [63:0] c, input logic [63:0] ra,
                        input logic [31:0] im, input logic [3:0] fl);
        PS = ps; PCsel = sel; IL = il; SL = sl;
        constant = c; reg_a = ra; imem_data = im; alu_flags = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        step(2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
        step(2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
        chk("rst_pc", pc, 64'h100);
        chk("rst_fault", {63'h0, pc_fault}, 64'h0);
        reset = 1'b0;

        // normal fetch
        step(2'b01, 0, 1, 0, 0, 0, 32'h91000421, 4'h0);
        chk("t1_I", {32'h0, I}, 64'h91000421);
        chk("t1_ipc", instr_pc, 64'h100);
        chk("t1_pc", pc, 64'h104);
        chk("t1_pc4", pc4, 64'h104);

        // relative branch with negative offset from instr_pc
        step(2'b10, 0, 0, 0, 0, 64'h200, 0, 4'h0);
        step(2'b01, 0, 1, 0, 0, 0, 32'h8B020020, 4'h0);
        chk("t2_ipc", instr_pc, 64'h200);
        chk("t2_pc204", pc, 64'h204);
        step(2'b11, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 4'h0);
        chk("t2_pc", pc, 64'h1F8);
        chk("t2_fault", {63'h0, pc_fault}, 64'h0);

        // absolute, then misaligned absolute
        step(2'b10, 0, 0, 0, 0, 64'h3000, 0, 4'h0);
        chk("t3_pc", pc, 64'h3000);
        step(2'b10, 0, 0, 0, 0, 64'h3002, 0, 4'h0);
        chk("t3_pcmis", pc, 64'h3000);
        chk("t3_fault", {63'h0, pc_fault}, 64'h1);
        step(2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
        chk("t3_sticky", {63'h0, pc_fault}, 64'h1);

        // status load and live bit 0
        step(2'b00, 0, 0, 1, 0, 0, 0, 4'b1010);
        chk("t4_st", {59'h0, status}, 64'b10100);
        step(2'b00, 0, 0, 0, 0, 0, 0, 4'b0001);
        chk("t4_live", {59'h0, status}, 64'b10101);

        // wrap-around and hold
        step(2'b10, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 4'h0);
        step(2'b01, 0, 0, 0, 0, 0, 0, 4'h0);
        chk("t5_wrap", pc, 64'h0);
        chk("t5_fault", {63'h0, pc_fault}, 64'h1);
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 1, 0, 0, 64'h55, 64'h77, 0, 4'h0);
            chk("t5_hold", pc, 64'h0);
        end

        // IL together with a relative branch: base is old instr_pc
        step(2'b11, 1, 1, 0, 64'h4, 0, 32'hAAAA5555, 4'h0);
        chk("ilb_pc", pc, 64'h210);
        chk("ilb_ipc", instr_pc, 64'h0);
        chk("ilb_I", {32'h0, I}, 64'hAAAA5555);

        // reset overrides strobes
        reset = 1'b1;
        step(2'b11, 1, 1, 1, 64'h8, 0, 32'h12345678, 4'b1111);
        chk("t6_pc", pc, RPC);
        chk("t6_I", {32'h0, I}, 64'h0);
        chk("t6_st", {59'h0, status}, 64'b00001);
        chk("t6_fault", {63'h0, pc_fault}, 64'h0);
        reset = 1'b0;
        step(2'b01, 0, 1, 0, 0, 0, 32'hD65F03C0, 4'h0);
        chk("t6_fetch", pc, 64'h104);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
